// File: rtl/wfg_wb_loader_if.sv
// Wishbone classic write-master bundle between the script loader and the
// waveform generator register bus.
interface wfg_wb_loader_if #(
  parameter int BUSW = 32
);
  logic            wbm_cyc;
  logic            wbm_stb;
  logic            wbm_we;
  logic [BUSW-1:0] wbm_adr;
  logic [BUSW-1:0] wbm_dat;
  logic            wbm_ack;

  modport master (
    output wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat,
    input  wbm_ack
  );

  modport slave (
    input  wbm_cyc, wbm_stb, wbm_we, wbm_adr, wbm_dat,
    output wbm_ack
  );
endinterface

// File: rtl/wfg_wb_loader.sv
// Replays an {address, data} register-write script from single-port SRAM as
// Wishbone classic writes into the waveform generator.
//
// state    | meaning
// IDLE     | waiting for start
// RD_ADR   | SRAM read of entry address word
// WAIT_ADR | address word on dout0_i; null page ends the script
// RD_DAT   | SRAM read of entry data word
// WAIT_DAT | data word on dout0_i; latch bus outputs, arm timeout
// WRITE    | Wishbone write in flight
// DONE     | terminator reached
// ERROR    | ack timeout or script overran the memory
module wfg_wb_loader #(
  parameter int BUSW    = 32,
  parameter int AW      = 10,
  parameter int TIMEOUT = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [1:0]      err_code_o,
  output logic [AW-1:0]   count_o,
  output logic            csb0_o,
  output logic [AW-1:0]   addr0_o,
  input  logic [BUSW-1:0] dout0_i,
  wfg_wb_loader_if.master wbm
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW-1:0] LAST_PAIR = {{(AW-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADR, S_WAIT_ADR, S_RD_DAT, S_WAIT_DAT, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   count_q, count_d;
  logic [BUSW-1:0] adr_q, adr_d;
  logic [BUSW-1:0] wb_adr_q, wb_adr_d;
  logic [BUSW-1:0] wb_dat_q, wb_dat_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      err_code_q, err_code_d;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      count_q    <= '0;
      adr_q      <= '0;
      wb_adr_q   <= '0;
      wb_dat_q   <= '0;
      tmo_q      <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
      adr_q      <= adr_d;
      wb_adr_q   <= wb_adr_d;
      wb_dat_q   <= wb_dat_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    adr_d      = adr_q;
    wb_adr_d   = wb_adr_q;
    wb_dat_d   = wb_dat_q;
    tmo_d      = tmo_q;
    err_code_d = err_code_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          // entries are word pairs, so the script always starts on an even word
          ptr_d      = base_addr_i & ~AW'(1);
          count_d    = '0;
          err_code_d = 2'b00;
          state_d    = S_RD_ADR;
        end
      end
      S_RD_ADR: state_d = S_WAIT_ADR;
      S_WAIT_ADR: begin
        if (dout0_i[BUSW-1:4] == '0) begin
          state_d = S_DONE;
        end else begin
          adr_d   = dout0_i;
          state_d = S_RD_DAT;
        end
      end
      S_RD_DAT: state_d = S_WAIT_DAT;
      S_WAIT_DAT: begin
        // bus outputs only change on entry to WRITE so they hold between writes
        wb_adr_d = adr_q;
        wb_dat_d = dout0_i;
        tmo_d    = TW'(TIMEOUT - 1);
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        if (wbm.wbm_ack) begin
          count_d = count_q + AW'(1);
          ptr_d   = ptr_q + AW'(2);
          if (ptr_q == LAST_PAIR) begin
            err_code_d = 2'b10;
            state_d    = S_ERROR;
          end else begin
            state_d = S_RD_ADR;
          end
        end else if (tmo_q == '0) begin
          err_code_d = 2'b01;
          state_d    = S_ERROR;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done_o     = (state_q == S_DONE);
  assign error_o    = (state_q == S_ERROR);
  assign err_code_o = err_code_q;
  assign count_o    = count_q;
  assign csb0_o     = !((state_q == S_RD_ADR) || (state_q == S_RD_DAT));
  assign addr0_o    = (state_q == S_RD_DAT) ? ptr_q + AW'(1) : ptr_q;

  assign wbm.wbm_cyc = (state_q == S_WRITE);
  assign wbm.wbm_stb = (state_q == S_WRITE);
  assign wbm.wbm_we  = (state_q == S_WRITE);
  assign wbm.wbm_adr = wb_adr_q;
  assign wbm.wbm_dat = wb_dat_q;

endmodule

// File: tb/tb_wfg_wb_loader.sv
// Directed bench for wfg_wb_loader: behavioural SRAM and Wishbone slave with
// programmable ack latency, each scenario checked against hand-computed values.
module tb_wfg_wb_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base = '0;
  logic        busy, done, err, csb0;
  logic [1:0]  err_code;
  logic [9:0]  count, addr0;
  logic [31:0] dout0 = '0;

  wfg_wb_loader_if #(.BUSW(32)) wb ();

  wfg_wb_loader #(.BUSW(32), .AW(10), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .base_addr_i(base),
    .busy_o(busy), .done_o(done), .error_o(err), .err_code_o(err_code),
    .count_o(count), .csb0_o(csb0), .addr0_o(addr0), .dout0_i(dout0), .wbm(wb)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  int          ack_n = 2;   // ack in the ack_n-th WRITE cycle; 0 = never
  int          stb_run = 0, stb_max = 0, busy_cycles = 0, n_writes = 0;
  logic [31:0] log_adr [0:7];
  logic [31:0] log_dat [0:7];
  int          n_cmp = 0, n_bad = 0;

  initial wb.wbm_ack = 1'b0;

  always @(negedge clk) begin
    if (!csb0) dout0 = mem[addr0];
    if (busy) busy_cycles++;
    if (wb.wbm_stb) stb_run++; else stb_run = 0;
    if (stb_run > stb_max) stb_max = stb_run;
    wb.wbm_ack = wb.wbm_stb && (ack_n != 0) && (stb_run == ack_n);
    if (wb.wbm_ack && n_writes < 8) begin
      log_adr[n_writes] = wb.wbm_adr;
      log_dat[n_writes] = wb.wbm_dat;
      n_writes++;
    end
  end

  task automatic pulse_start(input logic [9:0] b);
    @(negedge clk);
    busy_cycles = 0; n_writes = 0; stb_max = 0;
    base = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit to);
    to = 1'b1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_done_err got=%0b%0b exp=00", done, err); end
    n_cmp++; if (err_code !== 2'b00) begin n_bad++; $display("FAIL reset_code got=%b exp=00", err_code); end
    n_cmp++; if (count !== 10'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (csb0 !== 1'b1 || addr0 !== 10'd0) begin n_bad++; $display("FAIL reset_mem got csb=%0b addr=%h exp 1/000", csb0, addr0); end
    n_cmp++; if ({wb.wbm_cyc, wb.wbm_stb, wb.wbm_we} !== 3'b000) begin n_bad++; $display("FAIL reset_wb_ctl got=%b exp=000", {wb.wbm_cyc, wb.wbm_stb, wb.wbm_we}); end
    n_cmp++; if (wb.wbm_adr !== 32'd0 || wb.wbm_dat !== 32'd0) begin n_bad++; $display("FAIL reset_wb_bus got adr=%h dat=%h exp 0/0", wb.wbm_adr, wb.wbm_dat); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bit to;
    ack_n = 2;
    pulse_start(10'h010);
    n_cmp++; if (busy !== 1'b1 || csb0 !== 1'b0) begin n_bad++; $display("FAIL basic_start got busy=%0b csb=%0b exp 1/0", busy, csb0); end
    n_cmp++; if (addr0 !== 10'h010) begin n_bad++; $display("FAIL basic_addr0 got=%h exp=010", addr0); end
    wait_idle(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL basic_timeout got=busy exp=idle"); end
    n_cmp++; if (n_writes !== 2) begin n_bad++; $display("FAIL basic_nwrites got=%0d exp=2", n_writes); end
    n_cmp++; if (log_adr[0] !== 32'h10 || log_dat[0] !== 32'h1) begin n_bad++; $display("FAIL basic_w0 got %h<-%h exp 10<-1", log_adr[0], log_dat[0]); end
    n_cmp++; if (log_adr[1] !== 32'h44 || log_dat[1] !== 32'h7F) begin n_bad++; $display("FAIL basic_w1 got %h<-%h exp 44<-7f", log_adr[1], log_dat[1]); end
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL basic_done got done=%0b err=%0b exp 1/0", done, err); end
    n_cmp++; if (count !== 10'd2) begin n_bad++; $display("FAIL basic_count got=%0d exp=2", count); end
    n_cmp++; if (busy_cycles !== 14) begin n_bad++; $display("FAIL basic_busy_cycles got=%0d exp=14", busy_cycles); end
    n_cmp++; if (wb.wbm_adr !== 32'h44 || wb.wbm_dat !== 32'h7F) begin n_bad++; $display("FAIL basic_hold got %h/%h exp 44/7f", wb.wbm_adr, wb.wbm_dat); end
  endtask

  task automatic test_timeout;
    bit to;
    ack_n = 0;
    pulse_start(10'h020);
    wait_idle(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL tmo_wait got=busy exp=idle"); end
    n_cmp++; if (stb_max !== 16) begin n_bad++; $display("FAIL tmo_stb_len got=%0d exp=16", stb_max); end
    n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL tmo_error got err=%0b done=%0b exp 1/0", err, done); end
    n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL tmo_code got=%b exp=01", err_code); end
    n_cmp++; if (count !== 10'd0) begin n_bad++; $display("FAIL tmo_count got=%0d exp=0", count); end
    n_cmp++; if (wb.wbm_cyc !== 1'b0) begin n_bad++; $display("FAIL tmo_cyc got=%0b exp=0", wb.wbm_cyc); end
    n_cmp++; if (busy_cycles !== 20) begin n_bad++; $display("FAIL tmo_busy_cycles got=%0d exp=20", busy_cycles); end
  endtask

  task automatic test_overrun;
    bit to;
    ack_n = 2;
    pulse_start(10'h3FD);
    n_cmp++; if (addr0 !== 10'h3FC) begin n_bad++; $display("FAIL ovr_even_base got=%h exp=3fc", addr0); end
    wait_idle(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL ovr_wait got=busy exp=idle"); end
    n_cmp++; if (n_writes !== 2) begin n_bad++; $display("FAIL ovr_nwrites got=%0d exp=2", n_writes); end
    n_cmp++; if (log_adr[1] !== 32'h104 || log_dat[1] !== 32'hB) begin n_bad++; $display("FAIL ovr_w1 got %h<-%h exp 104<-b", log_adr[1], log_dat[1]); end
    n_cmp++; if (err !== 1'b1 || err_code !== 2'b10) begin n_bad++; $display("FAIL ovr_error got err=%0b code=%b exp 1/10", err, err_code); end
    n_cmp++; if (count !== 10'd2) begin n_bad++; $display("FAIL ovr_count got=%0d exp=2", count); end
  endtask

  task automatic test_term_first;
    bit to;
    ack_n = 2;
    pulse_start(10'h030);
    wait_idle(50, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL term_wait got=busy exp=idle"); end
    n_cmp++; if (stb_max !== 0) begin n_bad++; $display("FAIL term_no_bus got stb cycles=%0d exp=0", stb_max); end
    n_cmp++; if (busy_cycles !== 2) begin n_bad++; $display("FAIL term_busy_cycles got=%0d exp=2", busy_cycles); end
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL term_status got done=%0b err=%0b code=%b exp 1/0/00", done, err, err_code); end
    n_cmp++; if (count !== 10'd0) begin n_bad++; $display("FAIL term_count got=%0d exp=0", count); end
  endtask

  task automatic test_start_in_write;
    bit to, seen;
    ack_n = 4;
    pulse_start(10'h010);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb.wbm_stb) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL siw_stb got=no stb exp=stb"); end
    base = 10'h030; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL siw_wait got=busy exp=idle"); end
    n_cmp++; if (n_writes !== 2 || log_adr[1] !== 32'h44) begin n_bad++; $display("FAIL siw_writes got n=%0d adr1=%h exp 2/44", n_writes, log_adr[1]); end
    n_cmp++; if (count !== 10'd2 || done !== 1'b1) begin n_bad++; $display("FAIL siw_done got count=%0d done=%0b exp 2/1", count, done); end
    n_cmp++; if (busy_cycles !== 18) begin n_bad++; $display("FAIL siw_busy_cycles got=%0d exp=18", busy_cycles); end
  endtask

  task automatic test_reset_mid_write;
    bit to, seen;
    ack_n = 2;
    pulse_start(10'h010);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (count == 10'd1 && wb.wbm_stb) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rmw_reach got=no second write exp=second write"); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (wb.wbm_cyc !== 1'b0 || wb.wbm_stb !== 1'b0) begin n_bad++; $display("FAIL rmw_bus_drop got cyc=%0b stb=%0b exp 0/0", wb.wbm_cyc, wb.wbm_stb); end
    n_cmp++; if (busy !== 1'b0 || count !== 10'd0) begin n_bad++; $display("FAIL rmw_state got busy=%0b count=%0d exp 0/0", busy, count); end
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(10'h010);
    wait_idle(200, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL rmw_wait got=busy exp=idle"); end
    n_cmp++; if (n_writes !== 2 || log_adr[0] !== 32'h10 || log_dat[0] !== 32'h1) begin n_bad++; $display("FAIL rmw_replay got n=%0d w0=%h<-%h exp 2 10<-1", n_writes, log_adr[0], log_dat[0]); end
    n_cmp++; if (count !== 10'd2 || done !== 1'b1) begin n_bad++; $display("FAIL rmw_done got count=%0d done=%0b exp 2/1", count, done); end
  endtask

  task automatic test_ack_at_timeout;
    bit to;
    ack_n = 16;
    pulse_start(10'h010);
    wait_idle(300, to);
    n_cmp++; if (to) begin n_bad++; $display("FAIL aat_wait got=busy exp=idle"); end
    n_cmp++; if (err !== 1'b0 || done !== 1'b1) begin n_bad++; $display("FAIL aat_status got err=%0b done=%0b exp 0/1", err, done); end
    n_cmp++; if (count !== 10'd2 || n_writes !== 2) begin n_bad++; $display("FAIL aat_count got count=%0d n=%0d exp 2/2", count, n_writes); end
    n_cmp++; if (busy_cycles !== 42) begin n_bad++; $display("FAIL aat_busy_cycles got=%0d exp=42", busy_cycles); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'h10;  mem[10'h011] = 32'h1;
    mem[10'h012] = 32'h44;  mem[10'h013] = 32'h7F;
    mem[10'h014] = 32'h0;   mem[10'h015] = 32'hDEAD;
    mem[10'h020] = 32'h60;  mem[10'h021] = 32'h5;
    mem[10'h030] = 32'hF;   mem[10'h031] = 32'h1234;
    mem[10'h3FC] = 32'h100; mem[10'h3FD] = 32'hA;
    mem[10'h3FE] = 32'h104; mem[10'h3FF] = 32'hB;
    test_reset;
    test_basic;
    test_timeout;
    test_overrun;
    test_term_first;
    test_start_in_write;
    test_reset_mid_write;
    test_ack_at_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wfg_wb_loader.md
# wfg_wb_loader

Wishbone master sequencer that sits directly upstream of the waveform generator's register bus. After a start pulse it walks a register-write script stored in a single-port SRAM (one address word, then one data word, per entry) and replays each entry as a Wishbone classic write into the generator. This lets a complete waveform configuration (core, subcore, interconnect, stimuli, drivers) be loaded without host involvement.

## Interface

Parameters:
- BUSW, 32, Wishbone address/data width.
- AW, 10, script memory word-address width.
- TIMEOUT, 16, maximum cycles a write may wait for ack; must be at least 2.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  start pulse; sampled only when not busy.
- base_addr_i  in  AW  word address of the first script entry; sampled with start_i.
- busy_o  out  1  script playback in progress.
- done_o  out  1  terminator reached; held until next accepted start.
- error_o  out  1  playback aborted; held until next accepted start.
- err_code_o  out  2  01 ack timeout, 10 memory overrun, 00 otherwise.
- count_o  out  AW  number of writes acknowledged since last accepted start.
- csb0_o  out  1  script memory chip select, active-low.
- addr0_o  out  AW  script memory word address.
- dout0_i  in  32  script memory read data; valid the cycle after csb0_o=0.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_adr_o  out  BUSW  write address.
- wbm_dat_o  out  BUSW  write data.
- wbm_ack_i  in  1  slave acknowledge.

## Operation

- States: IDLE, RD_ADR, WAIT_ADR, RD_DAT, WAIT_DAT, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR, start_i=1: ptr<=base_addr_i, count<=0, done/error/err_code cleared, go RD_ADR. start_i in any other state is ignored.
- RD_ADR: csb0_o=0, addr0_o=ptr; go WAIT_ADR.
- WAIT_ADR: if dout0_i[BUSW-1:4]==0 (null page) it is the terminator: go DONE. Otherwise adr_reg<=dout0_i, go RD_DAT.
- RD_DAT: csb0_o=0, addr0_o=ptr+1; go WAIT_DAT.
- WAIT_DAT: dat_reg<=dout0_i; timeout counter cleared; go WRITE.
- WRITE:
  - cyc=stb=we=1, wbm_adr_o=adr_reg, wbm_dat_o=dat_reg.
  - On ack: count+1, ptr+2. If old ptr == 2^AW-2, go ERROR with code 10 (overrun; the next pair would wrap). Otherwise go RD_ADR.
  - No ack after TIMEOUT cycles in WRITE: go ERROR with code 01, count unchanged.
  - Ack on the same cycle the timeout expires counts as success; ack wins.
- An entry at ptr == 2^AW-1 is unreachable, because base_addr_i is forced even by ignoring bit 0.
- DONE: done_o=1. ERROR: error_o=1. Both are idle-equivalent for start.
- Reset asserted at any time: all state and outputs go to reset values immediately, and any in-flight bus cycle is dropped.

## Timing

- Reset values:
  - busy_o=0, done_o=0, error_o=0, err_code_o=00, count_o=0.
  - csb0_o=1, addr0_o=0.
  - wbm_cyc_o=wbm_stb_o=wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0.
- All outputs are registered or decoded from state only; there is no combinational path from wbm_ack_i or dout0_i to any output.
- Start sampled at edge k: busy_o=1 and csb0_o=0 from edge k onward.
- Per entry: 4 cycles of memory access plus N cycles in WRITE, where N ≥ 1 and ack arrives in the N-th cycle. A slave that acks one cycle after stb gives 6 cycles per entry.
- cyc/stb deassert on the edge that samples ack; there are no back-to-back stb cycles.
- busy_o falls on the edge entering DONE/ERROR; done_o/error_o rise on the same edge.
- The terminator costs 2 cycles after the last write.
- wbm_adr_o/wbm_dat_o hold their last values outside WRITE.

## Test plan

- Script at base 0x010: {0x10,0x1},{0x44,0x7F},{0x00,X}, slave acking 1 cycle after stb:
  - expect writes 0x10←0x1 then 0x44←0x7F;
  - done_o=1, count_o=2;
  - busy_o high for exactly 14 cycles.
- Slave never acks, TIMEOUT=16, script {0x60,0x5}:
  - stb high exactly 16 cycles, then error_o=1, err_code_o=01, count_o=0, cyc_o=0.
- base_addr_i=0x3FC with AW=10 and valid entries at 0x3FC and 0x3FE:
  - two writes complete, then error_o=1, err_code_o=10, count_o=2.
- Terminator first (dout0_i=0x0000000F at base): no Wishbone activity; done_o after 2 cycles; count_o=0.
- start_i pulsed during WRITE: ignored, playback unaffected. wb_rst_ni dropped mid-WRITE: cyc/stb/busy go 0 asynchronously and count_o clears. After release, a new start replays from base.
- Ack arriving on the TIMEOUT-th cycle: write counted, playback continues, no error.
